// File: rtl/loop_pkg.sv
// Shared types for the hardware loop controller: FSM state, LIFO entry layout
// and the default widths and nesting depth.
package loop_pkg;

    localparam int LOOP_CTR_W = 8;
    localparam int LOOP_PC_W  = 10;
    localparam int LOOP_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } loop_state_t;

    typedef struct packed {
        logic [LOOP_CTR_W-1:0] count;
        logic [LOOP_PC_W-1:0]  pc;
    } loop_entry_t;

endpackage

// File: rtl/loop_stack.sv
// LIFO of loop entries. Within one edge the top is decremented or popped first,
// then a push lands; a simultaneous pop and push therefore replaces the top entry.
module loop_stack
    import loop_pkg::*;
#(
    parameter int DEPTH = LOOP_DEPTH
) (
    input  logic                       clk,
    input  logic                       flush,
    input  logic                       push,
    input  loop_entry_t                push_entry,
    input  logic                       pop,
    input  logic                       dec_top,
    output loop_entry_t                top,
    output logic [$clog2(DEPTH):0]     depth
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);
    localparam logic [DW-1:0]         DEPTH_ONE = DW'(1);
    localparam logic [LOOP_CTR_W-1:0] CNT_ONE   = LOOP_CTR_W'(1);

    loop_entry_t       entries_r [DEPTH];
    logic [DW-1:0]     depth_r;
    logic [IW-1:0]     top_idx_s;
    logic [IW-1:0]     push_idx_s;

    assign top_idx_s  = IW'(depth_r - DEPTH_ONE);
    assign push_idx_s = IW'(depth_r);
    // An empty stack reports an all-zero top so the outputs read as reset values.
    assign top        = (depth_r == DW'(0)) ? loop_entry_t'('0) : entries_r[top_idx_s];
    assign depth      = depth_r;

    // Entry storage and occupancy update.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            depth_r <= DW'(0);
        end else begin
            if (dec_top) begin
                entries_r[top_idx_s].count <= entries_r[top_idx_s].count - CNT_ONE;
            end
            if (pop) begin
                entries_r[top_idx_s] <= push ? push_entry : loop_entry_t'('0);
            end else if (push) begin
                entries_r[push_idx_s] <= push_entry;
            end
            depth_r <= depth_r + DW'(push) - DW'(pop);
        end
    end

endmodule

// File: rtl/loop_counter_ctrl.sv
// Hardware loop controller: pushes loops on LoopStart, decides branch-back on
// LoopEndHit, and latches a sticky fault on stack overflow or underflow.
module loop_counter_ctrl
    import loop_pkg::*;
#(
    parameter int CTR_W = LOOP_CTR_W,
    parameter int PC_W  = LOOP_PC_W,
    parameter int DEPTH = LOOP_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     LoopStart,
    input  logic [CTR_W-1:0]         LoopCount,
    input  logic [PC_W-1:0]          BodyPC,
    input  logic                     LoopEndHit,
    output logic                     Taken,
    output logic [PC_W-1:0]          TargetPC,
    output logic                     Skip,
    output logic [CTR_W-1:0]         CurCount,
    output logic [$clog2(DEPTH):0]   Depth,
    output logic                     Fault
);

    localparam int DW = $clog2(DEPTH) + 1;

    loop_state_t   state_r;
    loop_state_t   state_next_s;
    loop_entry_t   top_s;
    loop_entry_t   push_entry_s;
    logic          flush_s;
    logic          active_s;
    logic          empty_s;
    logic          end_ok_s;
    logic          underflow_s;
    logic          overflow_s;
    logic          start_s;
    logic          dec_s;
    logic          pop_s;
    logic          push_s;
    logic          skip_s;
    logic [DW-1:0] depth_after_s;
    logic [DW-1:0] depth_next_s;

    assign flush_s      = Reset | Clear;
    assign push_entry_s = '{count: LoopCount, pc: BodyPC};

    // Decision logic: end is applied to the current top before any push is considered.
    always_comb begin
        active_s      = 1'b0;
        empty_s       = 1'b0;
        end_ok_s      = 1'b0;
        underflow_s   = 1'b0;
        dec_s         = 1'b0;
        pop_s         = 1'b0;
        depth_after_s = Depth;
        start_s       = 1'b0;
        skip_s        = 1'b0;
        overflow_s    = 1'b0;
        push_s        = 1'b0;
        depth_next_s  = Depth;
        state_next_s  = state_r;

        active_s      = !flush_s && (state_r != FAULT);
        empty_s       = (Depth == DW'(0));
        end_ok_s      = active_s && LoopEndHit && !empty_s;
        underflow_s   = active_s && LoopEndHit && empty_s;
        dec_s         = end_ok_s && (top_s.count > CTR_W'(1));
        pop_s         = end_ok_s && !dec_s;
        depth_after_s = Depth - DW'(pop_s);
        start_s       = active_s && LoopStart && (LoopCount != CTR_W'(0));
        skip_s        = active_s && LoopStart && (LoopCount == CTR_W'(0));
        overflow_s    = start_s && (depth_after_s == DW'(DEPTH));
        push_s        = start_s && !overflow_s && !underflow_s;
        depth_next_s  = depth_after_s + DW'(push_s);

        case (state_r)
            IDLE, RUN: begin
                if (overflow_s || underflow_s) begin
                    state_next_s = FAULT;
                end else if (depth_next_s != DW'(0)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FAULT:   state_next_s = FAULT;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; Clear acts exactly like Reset.
    always_ff @(posedge Clk) begin
        if (flush_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    loop_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk        (Clk),
        .flush      (flush_s),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .dec_top    (dec_s),
        .top        (top_s),
        .depth      (Depth)
    );

    assign Taken    = dec_s;
    assign TargetPC = top_s.pc;
    assign Skip     = skip_s;
    assign CurCount = top_s.count;
    assign Fault    = (state_r == FAULT);

endmodule

// File: tb/tb_loop_counter_ctrl.sv
// Directed self-checking bench for loop_counter_ctrl with hand-computed expectations.
module tb_loop_counter_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Clear;
    logic       LoopStart;
    logic [7:0] LoopCount;
    logic [9:0] BodyPC;
    logic       LoopEndHit;
    logic       Taken;
    logic [9:0] TargetPC;
    logic       Skip;
    logic [7:0] CurCount;
    logic [2:0] Depth;
    logic       Fault;

    int checks   = 0;
    int failures = 0;

    loop_counter_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Clear      (Clear),
        .LoopStart  (LoopStart),
        .LoopCount  (LoopCount),
        .BodyPC     (BodyPC),
        .LoopEndHit (LoopEndHit),
        .Taken      (Taken),
        .TargetPC   (TargetPC),
        .Skip       (Skip),
        .CurCount   (CurCount),
        .Depth      (Depth),
        .Fault      (Fault)
    );

    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One decode cycle: drive, check combinational outputs mid-cycle, then clock.
    task automatic cyc(input string tag, input logic s, input logic [7:0] c, input logic [9:0] pc,
                       input logic e, input logic xt, input logic [9:0] xpc, input logic xs);
        LoopStart  = s;
        LoopCount  = c;
        BodyPC     = pc;
        LoopEndHit = e;
        #2;
        check_value({tag, "_taken"}, 32'(Taken), 32'(xt));
        check_value({tag, "_tpc"},   32'(TargetPC), 32'(xpc));
        check_value({tag, "_skip"},  32'(Skip), 32'(xs));
        @(posedge Clk);
        #1;
        LoopStart  = 1'b0;
        LoopCount  = 8'd0;
        BodyPC     = 10'd0;
        LoopEndHit = 1'b0;
    endtask

    task automatic post(input string tag, input logic [2:0] xd, input logic [7:0] xc, input logic xf);
        check_value({tag, "_depth"}, 32'(Depth), 32'(xd));
        check_value({tag, "_count"}, 32'(CurCount), 32'(xc));
        check_value({tag, "_fault"}, 32'(Fault), 32'(xf));
    endtask

    task automatic pulse_clear();
        Clear = 1'b1;
        @(posedge Clk);
        #1;
        Clear = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Clear = 1'b0; LoopStart = 1'b0; LoopCount = 8'd0;
        BodyPC = 10'd0; LoopEndHit = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        post("reset", 3'd0, 8'd0, 1'b0);
        check_value("reset_taken", 32'(Taken), 32'd0);
        check_value("reset_tpc",   32'(TargetPC), 32'd0);
        check_value("reset_skip",  32'(Skip), 32'd0);

        // Single loop of three iterations
        cyc("s_start", 1'b1, 8'd3, 10'h040, 1'b0, 1'b0, 10'h000, 1'b0);
        post("s_start", 3'd1, 8'd3, 1'b0);
        cyc("s_end1", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h040, 1'b0);
        post("s_end1", 3'd1, 8'd2, 1'b0);
        cyc("s_end2", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h040, 1'b0);
        post("s_end2", 3'd1, 8'd1, 1'b0);
        cyc("s_end3", 1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 10'h040, 1'b0);
        post("s_end3", 3'd0, 8'd0, 1'b0);

        // Zero-count loop is skipped
        cyc("zero", 1'b1, 8'd0, 10'h080, 1'b0, 1'b0, 10'h000, 1'b1);
        post("zero", 3'd0, 8'd0, 1'b0);

        // Nested loops
        cyc("n_outer", 1'b1, 8'd2, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0);
        cyc("n_inner", 1'b1, 8'd2, 10'h020, 1'b0, 1'b0, 10'h010, 1'b0);
        post("n_inner", 3'd2, 8'd2, 1'b0);
        cyc("n_e1", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h020, 1'b0);
        cyc("n_e2", 1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 10'h020, 1'b0);
        post("n_e2", 3'd1, 8'd2, 1'b0);
        cyc("n_e3", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h010, 1'b0);
        post("n_e3", 3'd1, 8'd1, 1'b0);
        cyc("n_inner2", 1'b1, 8'd2, 10'h020, 1'b0, 1'b0, 10'h010, 1'b0);
        cyc("n_e4", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h020, 1'b0);
        cyc("n_e5", 1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 10'h020, 1'b0);
        post("n_e5", 3'd1, 8'd1, 1'b0);
        cyc("n_e6", 1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 10'h010, 1'b0);
        post("n_e6", 3'd0, 8'd0, 1'b0);

        // Overflow: fifth start on a full stack
        for (int i = 1; i <= 4; i++) begin
            cyc("o_push", 1'b1, 8'd5, 10'(i), 1'b0, 1'b0, 10'(i - 1), 1'b0);
        end
        post("o_full", 3'd4, 8'd5, 1'b0);
        cyc("o_over", 1'b1, 8'd5, 10'h005, 1'b0, 1'b0, 10'h004, 1'b0);
        post("o_over", 3'd4, 8'd5, 1'b1);
        cyc("o_frozen", 1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 10'h004, 1'b0);
        post("o_frozen", 3'd4, 8'd5, 1'b1);
        pulse_clear();
        post("o_clear", 3'd0, 8'd0, 1'b0);

        // Underflow on an empty stack
        cyc("u_end", 1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0);
        post("u_end", 3'd0, 8'd0, 1'b1);
        pulse_clear();
        post("u_clear", 3'd0, 8'd0, 1'b0);

        // Full stack, final iteration of top, simultaneous start
        cyc("f_p1", 1'b1, 8'd3, 10'h011, 1'b0, 1'b0, 10'h000, 1'b0);
        cyc("f_p2", 1'b1, 8'd3, 10'h012, 1'b0, 1'b0, 10'h011, 1'b0);
        cyc("f_p3", 1'b1, 8'd3, 10'h013, 1'b0, 1'b0, 10'h012, 1'b0);
        cyc("f_p4", 1'b1, 8'd1, 10'h014, 1'b0, 1'b0, 10'h013, 1'b0);
        post("f_full", 3'd4, 8'd1, 1'b0);
        cyc("f_simul", 1'b1, 8'd7, 10'h100, 1'b1, 1'b0, 10'h014, 1'b0);
        post("f_simul", 3'd4, 8'd7, 1'b0);
        cyc("f_after", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h100, 1'b0);
        post("f_after", 3'd4, 8'd6, 1'b0);
        pulse_clear();

        // Reset in the middle of a long loop
        cyc("r_start", 1'b1, 8'd200, 10'h0AA, 1'b0, 1'b0, 10'h000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc("r_end", 1'b0, 8'd0, 10'h000, 1'b1, 1'b1, 10'h0AA, 1'b0);
        end
        post("r_mid", 3'd1, 8'd190, 1'b0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        post("r_after", 3'd0, 8'd0, 1'b0);
        check_value("r_after_taken", 32'(Taken), 32'd0);
        check_value("r_after_tpc",   32'(TargetPC), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
